// File: rtl/lcd_frame_ctrl_if.sv
// Configuration port for lcd_frame_ctrl: new square bounds offered with a
// valid/ready handshake, plus a one-cycle error pulse for rejected beats.
interface lcd_frame_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_err;
  logic [15:0] cfg_top;
  logic [15:0] cfg_bottom;
  logic [15:0] cfg_left;
  logic [15:0] cfg_right;

  // Producer of new bounds.
  modport master (
    output cfg_valid, cfg_top, cfg_bottom, cfg_left, cfg_right,
    input  cfg_ready, cfg_err
  );

  // The frame controller.
  modport slave (
    input  cfg_valid, cfg_top, cfg_bottom, cfg_left, cfg_right,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/lcd_frame_ctrl.sv
// LCD timing generator and frame-synchronous square-bounds configurator.
// Counters and sync/enable outputs are all registered from the next-state
// counter values, so every output lines up with PixelCount/LineCount.
// New bounds are held in shadow registers and committed only on the last
// pixel of a frame, so the renderer never sees a torn frame.
module lcd_frame_ctrl #(
  parameter int          H_ACTIVE   = 800,
  parameter int          H_FP       = 40,
  parameter int          H_SYNC     = 48,
  parameter int          H_BP       = 88,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 13,
  parameter int          V_SYNC     = 3,
  parameter int          V_BP       = 32,
  parameter logic [15:0] DEF_TOP    = 16'd100,
  parameter logic [15:0] DEF_BOTTOM = 16'd400,
  parameter logic [15:0] DEF_LEFT   = 16'd200,
  parameter logic [15:0] DEF_RIGHT  = 16'd400
) (
  input  logic              PixelClk,
  input  logic              nRST,
  lcd_frame_ctrl_if.slave   cfg_bus,
  output logic [15:0]       PixelCount,
  output logic [15:0]       LineCount,
  output logic              LCD_DE,
  output logic              LCD_HSYNC,
  output logic              LCD_VSYNC,
  output logic              frame_start,
  output logic [15:0]       sq_top,
  output logic [15:0]       sq_bottom,
  output logic [15:0]       sq_left,
  output logic [15:0]       sq_right
);

  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Low for the first edge after reset release so that cycle shows (0,0).
  logic        running;
  logic [15:0] px_nxt;
  logic [15:0] ln_nxt;
  logic        frame_end;

  logic        pending;
  logic        cfg_err_q;
  logic        cfg_fire;
  logic        cfg_bad;
  logic [15:0] sh_top, sh_bottom, sh_left, sh_right;

  assign frame_end         = (PixelCount == H_LAST) && (LineCount == V_LAST);
  assign cfg_bus.cfg_ready = !pending;
  assign cfg_bus.cfg_err   = cfg_err_q;
  assign cfg_fire          = cfg_bus.cfg_valid && !pending;
  assign cfg_bad           = (cfg_bus.cfg_top > cfg_bus.cfg_bottom) ||
                             (cfg_bus.cfg_left > cfg_bus.cfg_right);

  // Next-state counter values; outputs below are decoded from these.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    px_nxt = '0;
    ln_nxt = '0;
    if (running) begin
      if (PixelCount == H_LAST) begin
        ln_nxt = (LineCount == V_LAST) ? '0 : LineCount + 16'd1;
      end else begin
        px_nxt = PixelCount + 16'd1;
        ln_nxt = LineCount;
      end
    end
  end

  // Counters and registered timing outputs, aligned with the counters.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      running     <= 1'b0;
      PixelCount  <= '0;
      LineCount   <= '0;
      LCD_DE      <= 1'b0;
      LCD_HSYNC   <= 1'b1;
      LCD_VSYNC   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      running     <= 1'b1;
      PixelCount  <= px_nxt;
      LineCount   <= ln_nxt;
      LCD_DE      <= (px_nxt < H_ACT) && (ln_nxt < V_ACT);
      LCD_HSYNC   <= !((px_nxt >= HS_BEG) && (px_nxt < HS_END));
      LCD_VSYNC   <= !((ln_nxt >= VS_BEG) && (ln_nxt < VS_END));
      frame_start <= (px_nxt == '0) && (ln_nxt == '0);
    end
  end

  // Config handshake, shadow capture and commit at frame end.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pending   <= 1'b0;
      cfg_err_q <= 1'b0;
      sh_top    <= DEF_TOP;
      sh_bottom <= DEF_BOTTOM;
      sh_left   <= DEF_LEFT;
      sh_right  <= DEF_RIGHT;
      sq_top    <= DEF_TOP;
      sq_bottom <= DEF_BOTTOM;
      sq_left   <= DEF_LEFT;
      sq_right  <= DEF_RIGHT;
    end else begin
      cfg_err_q <= cfg_fire && cfg_bad;
      // A beat can only fire while nothing is pending, so commit and capture
      // never compete; a beat taken on the frame-end cycle waits a frame.
      if (frame_end && pending) begin
        pending   <= 1'b0;
        sq_top    <= sh_top;
        sq_bottom <= sh_bottom;
        sq_left   <= sh_left;
        sq_right  <= sh_right;
      end else if (cfg_fire && !cfg_bad) begin
        pending   <= 1'b1;
        sh_top    <= cfg_bus.cfg_top;
        sh_bottom <= cfg_bus.cfg_bottom;
        sh_left   <= cfg_bus.cfg_left;
        sh_right  <= cfg_bus.cfg_right;
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Directed bench for lcd_frame_ctrl. Horizontal timing is the panel's own;
// vertical timing is shortened to 9 lines (active 0..3, FP 4, SYNC 5..7,
// BP 8) so that a frame is 976*9 = 8784 cycles.
module tb_lcd_frame_ctrl;

  localparam int FRAME = 976 * 9;
  localparam int LAST_LN = 8;

  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic [15:0] PixelCount, LineCount;
  logic        LCD_DE, LCD_HSYNC, LCD_VSYNC, frame_start;
  logic [15:0] sq_top, sq_bottom, sq_left, sq_right;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0;

  lcd_frame_ctrl_if cfg_bus ();

  lcd_frame_ctrl #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(3), .V_BP(1)
  ) dut (
    .PixelClk   (clk),
    .nRST       (nRST),
    .cfg_bus    (cfg_bus),
    .PixelCount (PixelCount),
    .LineCount  (LineCount),
    .LCD_DE     (LCD_DE),
    .LCD_HSYNC  (LCD_HSYNC),
    .LCD_VSYNC  (LCD_VSYNC),
    .frame_start(frame_start),
    .sq_top     (sq_top),
    .sq_bottom  (sq_bottom),
    .sq_left    (sq_left),
    .sq_right   (sq_right)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_sq(input string tag, input int t, input int b, input int l, input int r);
    check({tag, ".top"},    32'(sq_top),    32'(t));
    check({tag, ".bottom"}, 32'(sq_bottom), 32'(b));
    check({tag, ".left"},   32'(sq_left),   32'(l));
    check({tag, ".right"},  32'(sq_right),  32'(r));
  endtask

  task automatic check_pos(input string tag, input int px, input int ln);
    check({tag, ".px"}, 32'(PixelCount), 32'(px));
    check({tag, ".ln"}, 32'(LineCount),  32'(ln));
  endtask

  // Advance (sampling on falling edges) until the counters show (px,ln).
  task automatic wait_at(input int px, input int ln);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (32'(PixelCount) == px && 32'(LineCount) == ln) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("reach(%0d,%0d)", px, ln), 32'(hit), 32'd1);
  endtask

  task automatic next;
    @(negedge clk);
  endtask

  task automatic offer(input int t, input int b, input int l, input int r);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_top    = 16'(t);
    cfg_bus.cfg_bottom = 16'(b);
    cfg_bus.cfg_left   = 16'(l);
    cfg_bus.cfg_right  = 16'(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_pos(tag, 0, 0);
    check({tag, ".de"},    32'(LCD_DE),            32'd0);
    check({tag, ".hsync"}, 32'(LCD_HSYNC),         32'd1);
    check({tag, ".vsync"}, 32'(LCD_VSYNC),         32'd1);
    check({tag, ".fs"},    32'(frame_start),       32'd0);
    check({tag, ".ready"}, 32'(cfg_bus.cfg_ready), 32'd1);
    check({tag, ".err"},   32'(cfg_bus.cfg_err),   32'd0);
    check_sq(tag, 100, 400, 200, 400);
  endtask

  initial begin
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_top    = '0;
    cfg_bus.cfg_bottom = '0;
    cfg_bus.cfg_left   = '0;
    cfg_bus.cfg_right  = '0;
    #2 nRST = 1'b0;
    repeat (3) next();

    // 1. Reset values, then the first cycle after release.
    check_reset_outputs("rst");
    nRST = 1'b1;
    next();
    check_pos("first", 0, 0);
    check("first.de", 32'(LCD_DE), 32'd1);
    check("first.fs", 32'(frame_start), 32'd1);
    t0 = cyc;

    // 2. Horizontal windows on line 0.
    wait_at(799, 0); check("de@799", 32'(LCD_DE), 32'd1);
    next();          check("de@800", 32'(LCD_DE), 32'd0);
    wait_at(839, 0); check("hs@839", 32'(LCD_HSYNC), 32'd1);
    next();          check("hs@840", 32'(LCD_HSYNC), 32'd0);
    wait_at(887, 0); check("hs@887", 32'(LCD_HSYNC), 32'd0);
    next();          check("hs@888", 32'(LCD_HSYNC), 32'd1);
    wait_at(975, 0); check("fs@975", 32'(frame_start), 32'd0);
    next();          check_pos("wrap", 0, 1);
    check("wrap.fs", 32'(frame_start), 32'd0);

    // Vertical windows.
    wait_at(0, 3);   check("de@l3", 32'(LCD_DE), 32'd1);
    wait_at(0, 4);   check("de@l4", 32'(LCD_DE), 32'd0);
    wait_at(975, 4); check("vs@975,4", 32'(LCD_VSYNC), 32'd1);
    next();          check("vs@0,5", 32'(LCD_VSYNC), 32'd0);
    wait_at(500, 6); check("vs@500,6", 32'(LCD_VSYNC), 32'd0);
    wait_at(975, 7); check("vs@975,7", 32'(LCD_VSYNC), 32'd0);
    next();          check("vs@0,8", 32'(LCD_VSYNC), 32'd1);

    // Frame period from one frame_start to the next.
    for (int i = 0; i < 2 * FRAME && !frame_start; i++) next();
    check("period", 32'(cyc - t0), 32'(FRAME));
    check_pos("period.pos", 0, 0);

    // 3. Well-formed beat is held until frame end.
    wait_at(100, 1);
    offer(50, 60, 10, 20);
    check("t3.ready_before", 32'(cfg_bus.cfg_ready), 32'd1);
    next();
    cfg_bus.cfg_valid = 1'b0;
    check("t3.ready_after", 32'(cfg_bus.cfg_ready), 32'd0);
    check("t3.err", 32'(cfg_bus.cfg_err), 32'd0);
    wait_at(975, LAST_LN);
    check_sq("t3.hold", 100, 400, 200, 400);
    next();
    check_pos("t3.commit", 0, 0);
    check_sq("t3.commit", 50, 60, 10, 20);
    check("t3.ready_back", 32'(cfg_bus.cfg_ready), 32'd1);

    // 4. Malformed beats: transferred, flagged, dropped.
    wait_at(200, 2);
    offer(300, 200, 0, 10);
    next();
    cfg_bus.cfg_valid = 1'b0;
    check("t4a.err", 32'(cfg_bus.cfg_err), 32'd1);
    check("t4a.ready", 32'(cfg_bus.cfg_ready), 32'd1);
    next();
    check("t4a.err_low", 32'(cfg_bus.cfg_err), 32'd0);
    offer(0, 5, 30, 20);
    next();
    cfg_bus.cfg_valid = 1'b0;
    check("t4b.err", 32'(cfg_bus.cfg_err), 32'd1);
    check("t4b.ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check_sq("t4", 50, 60, 10, 20);

    // 5. Beat on the frame-end cycle waits a whole frame.
    wait_at(975, LAST_LN);
    offer(1, 2, 3, 4);
    next();
    cfg_bus.cfg_valid = 1'b0;
    check_pos("t5.next", 0, 0);
    check_sq("t5.not_yet", 50, 60, 10, 20);
    check("t5.pending", 32'(cfg_bus.cfg_ready), 32'd0);
    wait_at(975, LAST_LN);
    check_sq("t5.hold", 50, 60, 10, 20);
    next();
    check_sq("t5.commit", 1, 2, 3, 4);
    check("t5.ready_back", 32'(cfg_bus.cfg_ready), 32'd1);

    // 6. Reset mid-frame with a beat pending.
    wait_at(100, 1);
    offer(7, 8, 9, 10);
    next();
    cfg_bus.cfg_valid = 1'b0;
    check("t6.pending", 32'(cfg_bus.cfg_ready), 32'd0);
    wait_at(500, 3);
    check("t6.de_before", 32'(LCD_DE), 32'd1);
    nRST = 1'b0;
    #1;
    check_reset_outputs("t6.rst");
    repeat (2) next();
    nRST = 1'b1;
    next();
    check_pos("t6.first", 0, 0);
    check("t6.first.fs", 32'(frame_start), 32'd1);
    wait_at(975, LAST_LN);
    next();
    check_sq("t6.discarded", 100, 400, 200, 400);
    check("t6.ready", 32'(cfg_bus.cfg_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
